// File: rtl/nrisc_ifetch_seq.sv
// Instruction-fetch sequencer: owns the fetch address, runs a single-outstanding
// req/ack handshake to instruction memory and feeds a 2-entry prefetch buffer.
module nrisc_ifetch_seq #(
  parameter int unsigned    TAM    = 16,
  parameter int unsigned    DW     = 16,
  parameter logic [TAM-1:0] RST_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     CORE_PC_ctrl,
  input  logic [TAM-1:0] CORE_PC_target,
  output logic [DW-1:0]  CORE_InstructionIN,
  output logic           CORE_Ivalid,
  output logic [TAM-1:0] CORE_PC,
  output logic           IDATA_req,
  output logic [TAM-1:0] IDATA_addr,
  input  logic           IDATA_ack,
  input  logic [DW-1:0]  IDATA_CORE_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_KILL
  } state_t;

  state_t         state_q, state_d;
  logic [TAM-1:0] fa_q, fa_d;
  logic [TAM-1:0] addr_q, addr_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [TAM-1:0] pc_q  [0:1];
  logic [TAM-1:0] pc_d  [0:1];
  logic [DW-1:0]  ins_q [0:1];
  logic [DW-1:0]  ins_d [0:1];

  logic       valid, redirect, pop, busy, ack_keep, tail_idx;
  logic [1:0] cnt_pop;

  always_comb begin
    valid    = (cnt_q != 2'd0);
    redirect = valid && CORE_PC_ctrl[1];
    pop      = valid && (CORE_PC_ctrl == 2'b01);
    busy     = (state_q != S_IDLE);
    ack_keep = (state_q == S_FETCH) && IDATA_ack && !redirect;

    state_d  = state_q;
    fa_d     = fa_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    cnt_pop  = cnt_q - {1'b0, pop};
    tail_idx = (cnt_pop != 2'd0);

    if (redirect) begin
      fa_d  = CORE_PC_ctrl[0] ? (pc_q[0] + CORE_PC_target) : CORE_PC_target;
      cnt_d = 2'd0;
    end else begin
      // Pop shifts the second entry to the head before the append, so a
      // same-cycle pop and ack at count=1 lands the new word at the head.
      if (pop) begin
        pc_d[0]  = pc_q[1];
        ins_d[0] = ins_q[1];
      end
      if (ack_keep) begin
        pc_d[tail_idx]  = fa_q;
        ins_d[tail_idx] = IDATA_CORE_out;
        fa_d            = fa_q + 1'b1;
      end
      cnt_d = cnt_pop + {1'b0, ack_keep};
    end

    // An outstanding request is never abandoned; a redirect only marks it dead.
    if (busy && !IDATA_ack) begin
      state_d = (redirect || state_q == S_KILL) ? S_KILL : S_FETCH;
    end else if (cnt_d < 2'd2) begin
      state_d = S_FETCH;
      addr_d  = fa_d;
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fa_q    <= RST_PC;
      addr_q  <= '0;
      cnt_q   <= 2'd0;
      pc_q    <= '{default: '0};
      ins_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

  assign IDATA_req          = !rst && (state_q != S_IDLE);
  assign IDATA_addr         = rst ? '0 : addr_q;
  assign CORE_Ivalid        = !rst && valid;
  assign CORE_PC            = (!rst && valid) ? pc_q[0]  : '0;
  assign CORE_InstructionIN = (!rst && valid) ? ins_q[0] : '0;

endmodule

// File: tb/tb_nrisc_ifetch_seq.sv
// Directed bench for nrisc_ifetch_seq: per-cycle vector table plus hand-written
// sequences for stalled-redirect and mid-fetch reset.
module tb_nrisc_ifetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctrl;
  logic [15:0] tgt;
  logic [15:0] instr, pc, addr;
  logic        ivalid, req, ack;
  logic [15:0] mem_data;

  int unsigned mem_delay;
  int unsigned wait_cnt;
  logic        ack_force;

  int n_chk  = 0;
  int n_fail = 0;

  nrisc_ifetch_seq #(.TAM(16), .DW(16), .RST_PC(16'h0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .CORE_PC_ctrl      (ctrl),
    .CORE_PC_target    (tgt),
    .CORE_InstructionIN(instr),
    .CORE_Ivalid       (ivalid),
    .CORE_PC           (pc),
    .IDATA_req         (req),
    .IDATA_addr        (addr),
    .IDATA_ack         (ack),
    .IDATA_CORE_out    (mem_data)
  );

  always #5 clk = ~clk;

  // Memory model: ack once the request has been up for mem_delay cycles.
  always @(posedge clk) begin
    if (!req || ack) wait_cnt <= 0;
    else             wait_cnt <= wait_cnt + 1;
  end
  assign ack      = ack_force || (req && (wait_cnt >= mem_delay));
  assign mem_data = addr ^ 16'hA5A5;

  typedef struct {
    logic [1:0]  ctrl;
    logic [15:0] tgt;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] eins;
    logic        ereq;
    logic [15:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] c, input logic [15:0] t, input logic ev,
                     input logic [15:0] epc, input logic [15:0] eins,
                     input logic ereq, input logic [15:0] eaddr);
    vec_t v;
    v.ctrl = c; v.tgt = t; v.ev = ev; v.epc = epc; v.eins = eins;
    v.ereq = ereq; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address is only meaningful while a request is up.
  task automatic chk_out(input string tag, input logic ev, input logic [15:0] epc,
                         input logic [15:0] eins, input logic ereq, input logic [15:0] eaddr);
    chk({tag, ".valid"}, {15'd0, ivalid}, {15'd0, ev});
    chk({tag, ".pc"},    pc,    epc);
    chk({tag, ".instr"}, instr, eins);
    chk({tag, ".req"},   {15'd0, req}, {15'd0, ereq});
    if (ereq) chk({tag, ".addr"}, addr, eaddr);
  endtask

  initial begin
    rst = 1'b1; ctrl = 2'b00; tgt = '0;
    mem_delay = 0; ack_force = 1'b0;

    // Vector table: outputs expected in a cycle, ctrl applied in that cycle.
    add(2'b00, 16'h0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    add(2'b00, 16'h0, 1'b1, 16'h0000, 16'hA5A5, 1'b1, 16'h0001);
    for (int unsigned i = 0; i < 3; i++)
      add(2'b00, 16'h0, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'h0000);
    add(2'b01, 16'h0, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'h0000);
    for (int unsigned k = 1; k <= 16; k++) begin
      logic [15:0] kk;
      kk = 16'(k);
      add((k == 16) ? 2'b11 : 2'b01, (k == 16) ? 16'hFFF8 : 16'h0,
          1'b1, kk, kk ^ 16'hA5A5, 1'b1, kk + 16'd1);
    end
    add(2'b10, 16'h3333, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0008);
    add(2'b10, 16'hFFFF, 1'b1, 16'h0008, 16'hA5AD, 1'b1, 16'h0009);
    add(2'b00, 16'h0,    1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF);
    add(2'b01, 16'h0,    1'b1, 16'hFFFF, 16'h5A5A, 1'b1, 16'h0000);
    add(2'b10, 16'hFFFE, 1'b1, 16'h0000, 16'hA5A5, 1'b1, 16'h0001);
    add(2'b00, 16'h0,    1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFE);
    add(2'b11, 16'h0003, 1'b1, 16'hFFFE, 16'h5A5B, 1'b1, 16'hFFFF);
    add(2'b00, 16'h0,    1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001);
    add(2'b00, 16'h0,    1'b1, 16'h0001, 16'hA5A4, 1'b1, 16'h0002);

    repeat (3) begin
      @(negedge clk);
      chk_out("reset", 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      chk("reset.addr", addr, 16'h0000);
    end
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].eins,
              vecs[i].ereq, vecs[i].eaddr);
      ctrl = vecs[i].ctrl;
      tgt  = vecs[i].tgt;
    end

    // Full buffer idles the request; set up head=3 with fetch of 4 stalled.
    @(negedge clk);
    chk_out("full", 1'b1, 16'h0001, 16'hA5A4, 1'b0, 16'h0);
    ctrl = 2'b10; tgt = 16'h0003;
    @(negedge clk);
    chk_out("jmp3", 1'b0, 16'h0, 16'h0, 1'b1, 16'h0003);
    ctrl = 2'b00;
    @(posedge clk); #1 mem_delay = 3;
    @(negedge clk);
    chk_out("stall.head", 1'b1, 16'h0003, 16'hA5A6, 1'b1, 16'h0004);
    ctrl = 2'b10; tgt = 16'h1234;
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_out($sformatf("kill%0d", c), 1'b0, 16'h0, 16'h0, 1'b1, 16'h0004);
      ctrl = 2'b00;
    end
    mem_delay = 0;
    @(negedge clk);
    chk_out("post_kill", 1'b0, 16'h0, 16'h0, 1'b1, 16'h1234);
    @(negedge clk);
    chk_out("jmp1234", 1'b1, 16'h1234, 16'hB791, 1'b1, 16'h1235);

    // Reset pulse with a pending request and an ack forced during reset.
    ctrl = 2'b10; tgt = 16'h0050;
    @(posedge clk); #1 mem_delay = 5;
    ctrl = 2'b00;
    @(negedge clk);
    chk_out("pend50", 1'b0, 16'h0, 16'h0, 1'b1, 16'h0050);
    rst = 1'b1; ack_force = 1'b1;
    #1;
    chk_out("in_rst", 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("in_rst.addr", addr, 16'h0000);
    @(negedge clk);
    chk_out("rst_edge", 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("rst_edge.addr", addr, 16'h0000);
    rst = 1'b0; ack_force = 1'b0; mem_delay = 0;
    @(negedge clk);
    chk_out("restart", 1'b0, 16'h0, 16'h0, 1'b1, 16'h0000);
    @(negedge clk);
    chk_out("restart.head", 1'b1, 16'h0000, 16'hA5A5, 1'b1, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nrisc_ifetch_seq.md
Name: nrisc_ifetch_seq

Overview:
Instruction-fetch sequencer for the NRISC core. It owns the fetch address and drives the instruction memory with a req/ack handshake. Fetched words go into a 2-entry prefetch buffer, and the buffer head is presented to the core. The core steers sequencing via CORE_PC_ctrl: hold, advance, absolute jump, or relative branch. Jumps and branches flush the buffer and discard any in-flight fetch.

Parameters:
TAM, 16, address width (PC and memory address)
DW, 16, instruction word width
RST_PC, 0, fetch address loaded at reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
CORE_PC_ctrl  input  2  00 hold, 01 advance, 10 absolute jump, 11 relative branch
CORE_PC_target  input  TAM  jump address (10) or two's-complement offset (11)
CORE_InstructionIN  output  DW  instruction at buffer head
CORE_Ivalid  output  1  buffer head valid
CORE_PC  output  TAM  address of the instruction on CORE_InstructionIN
IDATA_req  output  1  fetch request to instruction memory
IDATA_addr  output  TAM  fetch address
IDATA_ack  input  1  memory returns data this cycle
IDATA_CORE_out  input  DW  instruction word from memory, valid with IDATA_ack

Behaviour:
- Reset: synchronous, active-high.
  - rst=1 at an edge sets fa=RST_PC, buffer count=0, state=IDLE.
  - All outputs 0 while in reset (IDATA_req=0, CORE_Ivalid=0, CORE_InstructionIN=0, CORE_PC=0, IDATA_addr=0).
  - rst overrides everything, including an in-flight fetch. Any IDATA_ack during reset is ignored.
- State machine: IDLE (req=0), FETCH (req=1, result kept), KILL (req=1, result dropped).
- Request rules:
  - Only one request outstanding at a time.
  - IDATA_addr and IDATA_req stay stable from assertion until the ack cycle.
  - Request launch: enter FETCH with IDATA_addr=fa whenever the next-cycle buffer count is <2.
- Fetch completion (ack in FETCH): write {fa, IDATA_CORE_out} to the buffer tail, then fa<=fa+1 (mod 2^TAM, 0xFFFF wraps to 0x0000).
  - If room remains, req stays high next cycle with the new fa. A 1-cycle-ack memory therefore sustains 1 word/cycle.
- Latency: ack in cycle n gives CORE_Ivalid=1 in cycle n+1 (buffer was empty). First req is asserted in the first cycle after rst deasserts.
- Outputs: CORE_Ivalid=(count>0). CORE_InstructionIN and CORE_PC come from the head entry. Both are 0 when the buffer is empty.
- CORE_PC_ctrl is acted on only when CORE_Ivalid=1; otherwise it is ignored.
  - 00: nothing.
  - 01: pop head.
  - 10: flush buffer, fa<=CORE_PC_target.
  - 11: flush buffer, fa<=CORE_PC+CORE_PC_target, modulo 2^TAM. Offset is relative to the head instruction's address.
- Redirect while a request is outstanding: the handshake is not abandoned.
  - State moves to KILL, with req and addr held until ack.
  - The ack's data is discarded and fa is not incremented.
  - Next cycle a FETCH launches from the redirected fa.
  - A second redirect during KILL only updates fa.
- Same-cycle ack and redirect: the redirect wins, the acked word is discarded, and the next fetch comes from the new fa.
- Same-cycle pop (01) and ack: the buffer writes and pops in the same cycle, so count is unchanged. Head advances correctly even from count=1.
- Full buffer (count=2): req stays 0 until a pop. Req is asserted in the cycle after the pop.
- Empty buffer: ctrl is ignored and the core effectively stalls.

Test Plan:
- Reset release, RST_PC=0x0000, memory acks every cycle with data=addr^0xA5A5 -> req=1 at cycle 1. Ivalid=1 at cycle 2 with PC=0x0000 and instr=0xA5A5. With ctrl=01 held, PC runs 0,1,2,... one per cycle.
- ctrl=00 held for 6 cycles -> buffer holds PCs 0x0000 and 0x0001, req drops to 0. One 01 pulse makes req reassert the next cycle, and the head becomes 0x0001.
- Head PC=0x0010, ctrl=11 with target=0xFFF8 -> buffer flushed, Ivalid=0. Next req addr=0x0008, and the next valid head has PC=0x0008.
- Jump while memory is stalled (ack delayed 3 cycles) on addr 0x0004, ctrl=10 with target=0x1234 -> req held at 0x0004 until ack. That data never reaches the core; the next req addr is 0x1234.
- Wrap: jump to 0xFFFF, then advance -> head PCs are 0xFFFF then 0x0000. The 11 branch from 0xFFFE with offset 0x0003 lands at 0x0001.
- rst pulsed for 1 cycle mid-fetch (req pending, ack arrives during rst) -> outputs 0 during reset, the ack is ignored, and fetch restarts at RST_PC with an empty buffer.
